native2axil_bridge: RTL
=======================

# native2axil_bridge

Parametrised AXI4-Lite master bridge: converts the single-beat native register-access interface (valid/ready request, one-cycle done pulse) into AXI4-Lite transactions toward the UART-to-register fabric. Successor to the fixed 32-bit/4-bit bridge. It adds:
- parametric data and address width
- caller-supplied byte strobes
- fair arbitration between simultaneous read and write requests
- registered response status
- a compile-time response timeout

## Interface
Parameters:
- DW, 32, data width; multiple of 8, 8..64
- AW, 8, address width
- TIMEOUT_CYC, 1024, cycles allowed per transaction before abort (only with timeout compiled in); ≥4

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset; asynchronous, active-low
- wr_valid_i  in  1  write request
- wr_ready_o  out  1  bridge idle, request accepted when valid&ready
- wr_addr_i  in  AW  write address
- wr_data_i  in  DW  write data
- wr_strb_i  in  DW/8  byte enables
- wr_done_o  out  1  one-cycle write completion pulse
- wr_err_o  out  1  last write status (1 = SLVERR/DECERR/timeout)
- rd_valid_i  in  1  read request
- rd_ready_o  out  1  bridge idle (same as wr_ready_o)
- rd_addr_i  in  AW  read address
- rd_done_o  out  1  one-cycle read completion pulse
- rd_data_o  out  DW  last read data
- rd_err_o  out  1  last read status
- m_axi_aw{addr,valid,ready}, m_axi_w{data,strb,valid,ready}, m_axi_b{resp,valid,ready}, m_axi_ar{addr,valid,ready}, m_axi_r{data,resp,valid,ready}  standard AXI4-Lite master; widths AW, DW, DW/8, 2
- m_axi_awprot / m_axi_arprot  out  3  constant 3'b000

## Operation
- States: IDLE, WRITE, WR_RESP, READ, RD_DATA. Reset → IDLE.
- **Reset values:**
  - All valids, readies-to-slave, done and err outputs: 0.
  - rd_data_o, addresses, wdata, wstrb: 0.
  - wr_ready_o/rd_ready_o: 1.
- **Acceptance:** ready_o is 1 only in IDLE. A request is accepted on valid&ready. Address, data and strobe are registered.
- **Simultaneous write and read in IDLE:** grant goes to the kind not granted last (round-robin flag). After reset the flag favours write. The loser stays pending; the caller holds it.
- **WRITE:**
  - awvalid and wvalid assert together. Each drops independently on its own handshake (aw_done/w_done flags).
  - When both are done → WR_RESP with bready=1.
- **WR_RESP:** on bvalid, bready drops, wr_err_o ← (bresp≠0), wr_done_o pulses → IDLE.
- **READ:** arvalid until arready → RD_DATA with rready=1.
- **RD_DATA:** on rvalid, rd_data_o ← rdata, rd_err_o ← (rresp≠0), rd_done_o pulses → IDLE.
- **Held outputs:** rd_data_o and the err flags hold until the next completion of the same kind.
- **Ordering:** B is never accepted before both the AW and W handshakes. bready and rready are 0 outside their response states.
- **Reset mid-transaction:** all valids drop immediately (asynchronous). No done pulse is generated.

## Timing
- Zero-wait slave, write:
  - Accept at cycle 0; aw/wvalid high at cycle 1 with both handshakes there.
  - bready at cycle 2; bvalid seen at cycle 2.
  - wr_done_o at cycle 3; ready_o high at cycle 3.
- Zero-wait slave, read: arvalid at cycle 1, rvalid at cycle 2, rd_done_o and data at cycle 3.
- Back-to-back: a new request is accepted in the done cycle, so throughput is 1 transaction per 3 cycles.
- Done pulses last exactly one cycle. wr_done_o and rd_done_o are never high together.

## Configuration
- N2A_TIMEOUT_EN defined:
  - A counter clears on acceptance and increments every non-IDLE cycle.
  - When it reaches TIMEOUT_CYC, all AXI valids and readies drop, the matching err_o is set to 1, the done pulse fires and the FSM enters IDLE.
  - On a read timeout rd_data_o is left unchanged.
- Not defined: no counter; the bridge waits indefinitely for the slave. TIMEOUT_CYC is ignored.

## Test plan
- Zero-wait slave, write addr 0x10, data 0xDEADBEEF, strb 4'b0011 → AW/W carry those values; wr_done_o at cycle 3; wr_err_o=0.
- Slave with awready 3 cycles before wready (AW at cycle 2, W at cycle 5) → each valid drops on its own handshake; bready is first high at cycle 6.
- wr_valid_i and rd_valid_i asserted together and held for 4 transactions → grants alternate W,R,W,R starting with W.
- Read returning rresp=2'b10, rdata=0x1234 → rd_data_o=0x1234, rd_err_o=1, rd_done_o for one cycle.
- N2A_TIMEOUT_EN, TIMEOUT_CYC=8, slave never asserts bvalid → abort at cycle 8 after acceptance; wr_err_o=1; wr_done_o pulse; wr_ready_o=1 on the next cycle.
- rst_n_i pulsed low while arvalid is pending → arvalid is 0 immediately; no rd_done_o; IDLE and ready after reset release.

Source files
------------

// File: rtl/native2axil_bridge.sv
// Native valid/ready register-access requests to AXI4-Lite master transactions.
// Define N2A_TIMEOUT_EN to compile in the per-transaction response timeout.
module native2axil_bridge #(
    parameter int DW          = 32,
    parameter int AW          = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            wr_valid_i,
    output logic            wr_ready_o,
    input  logic [AW-1:0]   wr_addr_i,
    input  logic [DW-1:0]   wr_data_i,
    input  logic [DW/8-1:0] wr_strb_i,
    output logic            wr_done_o,
    output logic            wr_err_o,
    input  logic            rd_valid_i,
    output logic            rd_ready_o,
    input  logic [AW-1:0]   rd_addr_i,
    output logic            rd_done_o,
    output logic [DW-1:0]   rd_data_o,
    output logic            rd_err_o,
    output logic [AW-1:0]   m_axi_awaddr,
    output logic [2:0]      m_axi_awprot,
    output logic            m_axi_awvalid,
    input  logic            m_axi_awready,
    output logic [DW-1:0]   m_axi_wdata,
    output logic [DW/8-1:0] m_axi_wstrb,
    output logic            m_axi_wvalid,
    input  logic            m_axi_wready,
    input  logic [1:0]      m_axi_bresp,
    input  logic            m_axi_bvalid,
    output logic            m_axi_bready,
    output logic [AW-1:0]   m_axi_araddr,
    output logic [2:0]      m_axi_arprot,
    output logic            m_axi_arvalid,
    input  logic            m_axi_arready,
    input  logic [DW-1:0]   m_axi_rdata,
    input  logic [1:0]      m_axi_rresp,
    input  logic            m_axi_rvalid,
    output logic            m_axi_rready
);

    if (DW % 8 != 0 || DW < 8 || DW > 64 || TIMEOUT_CYC < 4) begin : g_bad_param
        $error("native2axil_bridge: illegal DW or TIMEOUT_CYC");
    end

    typedef enum logic [2:0] {IDLE, WRITE, WR_RESP, READ, RD_DATA} state_e;

    state_e            state_q, state_d;
    logic              awvalid_q, awvalid_d;
    logic              wvalid_q, wvalid_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic              rready_q, rready_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_done_q, rd_done_d;
    logic              wr_err_q, wr_err_d;
    logic              rd_err_q, rd_err_d;
    logic [DW-1:0]     rd_data_q, rd_data_d;
    logic [AW-1:0]     awaddr_q, awaddr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW/8-1:0]   wstrb_q, wstrb_d;
    logic [AW-1:0]     araddr_q, araddr_d;
    logic              wr_last_q, wr_last_d;   // 1: write was granted last
    logic              idle, wr_go, rd_go;

`ifdef N2A_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0]     cnt_q, cnt_d;
`endif

    assign idle  = (state_q == IDLE);
    assign wr_go = idle && wr_valid_i && (!rd_valid_i || !wr_last_q);
    assign rd_go = idle && rd_valid_i && !wr_go;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
        state_d   = state_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        bready_d  = bready_q;
        arvalid_d = arvalid_q;
        rready_d  = rready_q;
        wr_done_d = 1'b0;
        rd_done_d = 1'b0;
        wr_err_d  = wr_err_q;
        rd_err_d  = rd_err_q;
        rd_data_d = rd_data_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        araddr_d  = araddr_q;
        wr_last_d = wr_last_q;

        case (state_q)
            IDLE: begin
                if (wr_go) begin
                    state_d   = WRITE;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = wr_addr_i;
                    wdata_d   = wr_data_i;
                    wstrb_d   = wr_strb_i;
                    wr_last_d = 1'b1;
                end else if (rd_go) begin
                    state_d   = READ;
                    arvalid_d = 1'b1;
                    araddr_d  = rd_addr_i;
                    wr_last_d = 1'b0;
                end
            end
            WRITE: begin
                // A low valid in WRITE means that channel's handshake is done.
                awvalid_d = awvalid_q && !m_axi_awready;
                wvalid_d  = wvalid_q && !m_axi_wready;
                if (!awvalid_d && !wvalid_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (m_axi_bvalid) begin
                    state_d   = IDLE;
                    bready_d  = 1'b0;
                    wr_err_d  = (m_axi_bresp != 2'b00);
                    wr_done_d = 1'b1;
                end
            end
            READ: begin
                if (m_axi_arready) begin
                    state_d   = RD_DATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end
            end
            RD_DATA: begin
                if (m_axi_rvalid) begin
                    state_d   = IDLE;
                    rready_d  = 1'b0;
                    rd_data_d = m_axi_rdata;
                    rd_err_d  = (m_axi_rresp != 2'b00);
                    rd_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef N2A_TIMEOUT_EN
        cnt_d = idle ? '0 : cnt_q + 1'b1;
        // A real completion in the expiry cycle wins over the abort.
        if (!idle && state_d != IDLE && cnt_q == CW'(TIMEOUT_CYC - 1)) begin
            awvalid_d = 1'b0;
            wvalid_d  = 1'b0;
            bready_d  = 1'b0;
            arvalid_d = 1'b0;
            rready_d  = 1'b0;
            state_d   = IDLE;
            if (state_q == WRITE || state_q == WR_RESP) begin
                wr_err_d  = 1'b1;
                wr_done_d = 1'b1;
            end else begin
                rd_err_d  = 1'b1;
                rd_done_d = 1'b1;
            end
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            wr_done_q <= 1'b0;
            rd_done_q <= 1'b0;
            wr_err_q  <= 1'b0;
            rd_err_q  <= 1'b0;
            rd_data_q <= '0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            araddr_q  <= '0;
            wr_last_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            bready_q  <= bready_d;
            arvalid_q <= arvalid_d;
            rready_q  <= rready_d;
            wr_done_q <= wr_done_d;
            rd_done_q <= rd_done_d;
            wr_err_q  <= wr_err_d;
            rd_err_q  <= rd_err_d;
            rd_data_q <= rd_data_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            araddr_q  <= araddr_d;
            wr_last_q <= wr_last_d;
        end
    end

`ifdef N2A_TIMEOUT_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end
`endif

    assign wr_ready_o    = idle;
    assign rd_ready_o    = idle;
    assign wr_done_o     = wr_done_q;
    assign wr_err_o      = wr_err_q;
    assign rd_done_o     = rd_done_q;
    assign rd_data_o     = rd_data_q;
    assign rd_err_o      = rd_err_q;
    assign m_axi_awaddr  = awaddr_q;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_awvalid = awvalid_q;
    assign m_axi_wdata   = wdata_q;
    assign m_axi_wstrb   = wstrb_q;
    assign m_axi_wvalid  = wvalid_q;
    assign m_axi_bready  = bready_q;
    assign m_axi_araddr  = araddr_q;
    assign m_axi_arprot  = 3'b000;
    assign m_axi_arvalid = arvalid_q;
    assign m_axi_rready  = rready_q;

endmodule
